execute: RTL and testbench

Execute stage of the ppcpu pipeline, sitting between decode and the memory/writeback stage. It accepts one decoded instruction per handshake, computes the ALU result and the effective memory address, updates the flags register and resolves conditional jumps. It presents the result to memory/writeback as a one-cycle submit pulse. Because memory/writeback reads its data/address inputs combinationally for the whole bus transaction, this stage holds its outputs stable until the memory ack returns.

---
 rtl/execute.sv | 174 +++++++++++++++++
 tb/tb_execute.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// rtl/execute.sv - ppcpu execute stage: ALU, flags, effective address, jump resolution.
// Holds its result registers stable until memory/writeback acks a submitted bus access.
`ifndef RW
`define RW 16
`endif
`ifndef REGNO
`define REGNO 8
`endif

module execute (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_submit,
   output logic              o_ready,
   input  logic [3:0]        i_alu_op,
   input  logic [`RW-1:0]    i_reg_a,
   input  logic [`RW-1:0]    i_reg_b,
   input  logic [`RW-1:0]    i_imm,
   input  logic              i_use_imm,
   input  logic [`REGNO-1:0] i_reg_ie,
   input  logic              i_mem_access,
   input  logic              i_mem_we,
   input  logic              i_flags_we,
   input  logic              i_jump,
   input  logic [2:0]        i_jump_cond,
   output logic              o_submit,
   output logic [`RW-1:0]    o_data,
   output logic [`RW-1:0]    o_addr,
   output logic [`REGNO-1:0] o_reg_ie,
   output logic              o_mem_access,
   output logic              o_mem_we,
   input  logic              i_mem_ack,
   output logic              o_jump,
   output logic [`RW-1:0]    o_jump_addr,
   output logic [3:0]        o_flags
);

   localparam logic [3:0] OP_MOV = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_SBC = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_SAR = 4'd10;
   localparam logic [3:0] OP_NOT = 4'd11;
   localparam int         MSB    = `RW - 1;

   logic              pend;
   logic              busy;
   logic              accept;
   logic [`RW-1:0]    op_b;
   logic [`RW-1:0]    alu_res;
   logic              alu_c;
   logic              alu_o;
   logic [`RW:0]      sum;
   logic [2*`RW-1:0]  sh;
   logic [3:0]        shamt;
   logic              cin;
   logic [3:0]        alu_flags;
   logic              cond_ok;

   assign op_b     = i_use_imm ? i_imm : i_reg_b;
   assign shamt    = op_b[3:0];
   assign o_submit = pend & ~busy;
   // A pending memory op must not be overwritten before it has been submitted.
   assign o_ready  = ~busy & ~(pend & o_mem_access);
   assign accept   = i_submit & o_ready;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      sum     = '0;
      sh      = '0;
      cin     = 1'b0;
      case (i_alu_op)
         OP_MOV: alu_res = op_b;
         OP_ADD, OP_ADC: begin
            cin     = (i_alu_op == OP_ADC) & o_flags[1];
            sum     = {1'b0, i_reg_a} + {1'b0, op_b} + {{`RW{1'b0}}, cin};
            alu_res = sum[`RW-1:0];
            alu_c   = sum[`RW];
            alu_o   = (i_reg_a[MSB] == op_b[MSB]) & (alu_res[MSB] != i_reg_a[MSB]);
         end
         OP_SUB, OP_SBC: begin
            cin     = (i_alu_op == OP_SBC) & o_flags[1];
            sum     = {1'b0, i_reg_a} - {1'b0, op_b} - {{`RW{1'b0}}, cin};
            alu_res = sum[`RW-1:0];
            alu_c   = sum[`RW];
            alu_o   = (i_reg_a[MSB] != op_b[MSB]) & (alu_res[MSB] != i_reg_a[MSB]);
         end
         OP_AND: alu_res = i_reg_a & op_b;
         OP_OR:  alu_res = i_reg_a | op_b;
         OP_XOR: alu_res = i_reg_a ^ op_b;
         // Shifts run in a double-width window so the last bit out lands at a fixed index.
         OP_SHL: begin
            sh      = {{`RW{1'b0}}, i_reg_a} << shamt;
            alu_res = sh[`RW-1:0];
            alu_c   = sh[`RW];
         end
         OP_SHR: begin
            sh      = {i_reg_a, {`RW{1'b0}}} >> shamt;
            alu_res = sh[2*`RW-1:`RW];
            alu_c   = sh[`RW-1];
         end
         OP_SAR: begin
            sh      = $signed({i_reg_a, {`RW{1'b0}}}) >>> shamt;
            alu_res = sh[2*`RW-1:`RW];
            alu_c   = sh[`RW-1];
         end
         OP_NOT: alu_res = ~i_reg_a;
         default: alu_res = '0;
      endcase
   end

   assign alu_flags = {alu_o, alu_res[MSB], alu_c, (alu_res == '0)};

   always_comb begin
      cond_ok = 1'b0;
      case (i_jump_cond)
         3'd0: cond_ok = 1'b1;
         3'd1: cond_ok = o_flags[0];
         3'd2: cond_ok = ~o_flags[0];
         3'd3: cond_ok = o_flags[1];
         3'd4: cond_ok = ~o_flags[1];
         3'd5: cond_ok = o_flags[2];
         3'd6: cond_ok = ~o_flags[2];
         3'd7: cond_ok = o_flags[3];
         default: cond_ok = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend         <= 1'b0;
         busy         <= 1'b0;
         o_data       <= '0;
         o_addr       <= '0;
         o_reg_ie     <= '0;
         o_mem_access <= 1'b0;
         o_mem_we     <= 1'b0;
         o_jump       <= 1'b0;
         o_jump_addr  <= '0;
         o_flags      <= '0;
      end else begin
         o_jump <= 1'b0;
         if (accept) begin
            pend         <= 1'b1;
            o_data       <= (i_mem_access & i_mem_we) ? i_reg_b : alu_res;
            o_addr       <= i_reg_a + i_imm;
            o_reg_ie     <= i_reg_ie;
            o_mem_access <= i_mem_access;
            o_mem_we     <= i_mem_we;
            o_jump       <= i_jump & cond_ok;
            if (i_jump & cond_ok)
               o_jump_addr <= i_use_imm ? i_imm : i_reg_a;
            if (i_flags_we)
               o_flags <= alu_flags;
         end else if (o_submit) begin
            pend <= 1'b0;
         end
         // An ack arriving while idle falls through harmlessly: busy is already 0.
         if (o_submit & o_mem_access)
            busy <= 1'b1;
         else if (i_mem_ack)
            busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - randomized, model-checked bench for the execute stage.
module tb_execute;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_submit;
   logic        o_ready;
   logic [3:0]  i_alu_op;
   logic [15:0] i_reg_a, i_reg_b, i_imm;
   logic        i_use_imm;
   logic [7:0]  i_reg_ie;
   logic        i_mem_access, i_mem_we, i_flags_we, i_jump;
   logic [2:0]  i_jump_cond;
   logic        o_submit;
   logic [15:0] o_data, o_addr;
   logic [7:0]  o_reg_ie;
   logic        o_mem_access, o_mem_we;
   logic        i_mem_ack;
   logic        o_jump;
   logic [15:0] o_jump_addr;
   logic [3:0]  o_flags;

   int n_cmp = 0;
   int n_err = 0;
   int submit_cnt = 0;
   logic [3:0] model_flags;

   execute dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_submit(i_submit), .o_ready(o_ready),
      .i_alu_op(i_alu_op), .i_reg_a(i_reg_a), .i_reg_b(i_reg_b), .i_imm(i_imm),
      .i_use_imm(i_use_imm), .i_reg_ie(i_reg_ie), .i_mem_access(i_mem_access),
      .i_mem_we(i_mem_we), .i_flags_we(i_flags_we), .i_jump(i_jump),
      .i_jump_cond(i_jump_cond), .o_submit(o_submit), .o_data(o_data),
      .o_addr(o_addr), .o_reg_ie(o_reg_ie), .o_mem_access(o_mem_access),
      .o_mem_we(o_mem_we), .i_mem_ack(i_mem_ack), .o_jump(o_jump),
      .o_jump_addr(o_jump_addr), .o_flags(o_flags)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) if (o_submit === 1'b1) submit_cnt++;

   // Reference ALU from plain integer arithmetic; returns {O,N,C,Z,result}.
   function automatic logic [19:0] ref_alu(input int op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cf);
      int ua, ub, sa, sb, n, r, ss, ci;
      logic c, o;
      logic [15:0] res;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      n = ub & 15; c = 1'b0; o = 1'b0; r = 0; ss = 0;
      ci = ((op == 2) || (op == 4)) ? int'(cf) : 0;
      case (op)
         0: r = ub;
         1, 2: begin
            r = ua + ub + ci; c = (r > 65535);
            ss = sa + sb + ci; o = (ss > 32767) || (ss < -32768);
         end
         3, 4: begin
            r = ua - ub - ci; c = (ua < ub + ci);
            ss = sa - sb - ci; o = (ss > 32767) || (ss < -32768);
         end
         5: r = ua & ub;
         6: r = ua | ub;
         7: r = ua ^ ub;
         8: begin r = ua << n; c = (n != 0) && (((ua >> (16 - n)) & 1) == 1); end
         9: begin r = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
         10: begin r = sa >>> n; c = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
         11: r = ~ua;
         default: r = 0;
      endcase
      res = r[15:0];
      return {o, res[15], c, (res == 16'h0000), res};
   endfunction

   function automatic logic ref_cond(input int cond, input logic [3:0] f);
      case (cond)
         0: return 1'b1;
         1: return f[0];
         2: return !f[0];
         3: return f[1];
         4: return !f[1];
         5: return f[2];
         6: return !f[2];
         default: return f[3];
      endcase
   endfunction

   task automatic load_instr(input logic [3:0] op, input logic [15:0] a, b, imm,
                             input logic use_imm, input logic [7:0] ie,
                             input logic mem, we, fwe, jmp, input logic [2:0] cond);
      i_alu_op = op; i_reg_a = a; i_reg_b = b; i_imm = imm; i_use_imm = use_imm;
      i_reg_ie = ie; i_mem_access = mem; i_mem_we = we; i_flags_we = fwe;
      i_jump = jmp; i_jump_cond = cond;
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_submit = 1'b0; i_mem_ack = 1'b0;
      load_instr(4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      repeat (2) @(posedge i_clk);
      #1;
      n_cmp++; if ({o_submit, o_ready, o_jump} !== 3'b010) begin n_err++;
         $display("FAIL reset_ctl: got submit/ready/jump %b want 010", {o_submit, o_ready, o_jump}); end
      n_cmp++; if (o_flags !== 4'h0) begin n_err++;
         $display("FAIL reset_flags: got %h want 0", o_flags); end
      n_cmp++; if ({o_data, o_addr, o_jump_addr, o_reg_ie, o_mem_access, o_mem_we} !== 58'h0) begin n_err++;
         $display("FAIL reset_regs: data %h addr %h jaddr %h ie %h want all 0", o_data, o_addr, o_jump_addr, o_reg_ie); end
      @(negedge i_clk) i_rst = 1'b0;
      model_flags = 4'h0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_add_adc;
      int c0;
      c0 = submit_cnt;
      load_instr(4'd1, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      n_cmp++; if ({o_submit, o_data} !== {1'b1, 16'h0000}) begin n_err++;
         $display("FAIL add_data: got submit %b data %h want 1 0000", o_submit, o_data); end
      n_cmp++; if (o_flags !== 4'b0011) begin n_err++;
         $display("FAIL add_flags: got %b want 0011", o_flags); end
      load_instr(4'd2, 16'h0000, 16'h0000, 16'h0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      n_cmp++; if ({o_submit, o_data} !== {1'b1, 16'h0001}) begin n_err++;
         $display("FAIL adc_data: got submit %b data %h want 1 0001", o_submit, o_data); end
      @(posedge i_clk); #1;
      n_cmp++; if (o_submit !== 1'b0 || submit_cnt - c0 != 2) begin n_err++;
         $display("FAIL add_adc_submits: got %0d submits (o_submit %b) want 2 (0)", submit_cnt - c0, o_submit); end
      model_flags = 4'b0000;
   endtask

   task automatic test_sub;
      load_instr(4'd3, 16'h8000, 16'h0001, 16'h0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      n_cmp++; if ({o_data, o_flags} !== {16'h7FFF, 4'b1000}) begin n_err++;
         $display("FAIL sub_ovf: got data %h flags %b want 7fff 1000", o_data, o_flags); end
      model_flags = 4'b1000;
      @(posedge i_clk); #1;
   endtask

   task automatic test_load;
      int c0;
      c0 = submit_cnt;
      load_instr(4'd0, 16'h1000, 16'h0, 16'h0010, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      n_cmp++; if ({o_addr, o_submit, o_ready, o_mem_access} !== {16'h1010, 3'b101}) begin n_err++;
         $display("FAIL load_issue: got addr %h submit %b ready %b mem %b want 1010 1 0 1", o_addr, o_submit, o_ready, o_mem_access); end
      load_instr(4'd1, 16'h0003, 16'h0004, 16'h0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         n_cmp++; if ({o_addr, o_reg_ie, o_ready, o_submit} !== {16'h1010, 8'h02, 2'b00}) begin n_err++;
            $display("FAIL load_hold%0d: got addr %h ie %h ready %b submit %b want 1010 02 0 0", i, o_addr, o_reg_ie, o_ready, o_submit); end
      end
      i_mem_ack = 1'b1;
      #1;
      n_cmp++; if ({o_ready, o_submit} !== 2'b00) begin n_err++;
         $display("FAIL load_ack_comb: got ready %b submit %b want 0 0", o_ready, o_submit); end
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      n_cmp++; if ({o_ready, o_addr} !== {1'b1, 16'h1010} || submit_cnt - c0 != 1) begin n_err++;
         $display("FAIL load_release: got ready %b addr %h submits %0d want 1 1010 1", o_ready, o_addr, submit_cnt - c0); end
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      n_cmp++; if ({o_submit, o_data, o_reg_ie} !== {1'b1, 16'h0007, 8'h04}) begin n_err++;
         $display("FAIL load_next: got submit %b data %h ie %h want 1 0007 04", o_submit, o_data, o_reg_ie); end
      @(posedge i_clk); #1;
   endtask

   task automatic test_store;
      load_instr(4'd0, 16'h2000, 16'hBEEF, 16'h0004, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      n_cmp++; if ({o_data, o_addr, o_mem_we, o_submit} !== {16'hBEEF, 16'h2004, 2'b11}) begin n_err++;
         $display("FAIL store_issue: got data %h addr %h we %b submit %b want beef 2004 1 1", o_data, o_addr, o_mem_we, o_submit); end
      for (int i = 0; i < 4; i++) begin
         load_instr(4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 3'd0);
         @(posedge i_clk); #1;
         n_cmp++; if ({o_data, o_addr, o_mem_we, o_submit, o_jump, o_flags} !== {16'hBEEF, 16'h2004, 3'b100, model_flags}) begin n_err++;
            $display("FAIL store_hold%0d: got data %h addr %h we %b submit %b jump %b flags %b", i, o_data, o_addr, o_mem_we, o_submit, o_jump, o_flags); end
      end
      i_submit = 1'b0;
      i_mem_ack = 1'b1;
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      n_cmp++; if ({o_ready, o_submit} !== 2'b10) begin n_err++;
         $display("FAIL store_release: got ready %b submit %b want 1 0", o_ready, o_submit); end
   endtask

   task automatic test_jump;
      load_instr(4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      model_flags = 4'b0001;
      load_instr(4'd0, 16'h1234, 16'h0, 16'h0040, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
      @(posedge i_clk); #1;
      n_cmp++; if (o_jump !== 1'b0) begin n_err++;
         $display("FAIL jump_nz: got o_jump %b want 0", o_jump); end
      load_instr(4'd0, 16'h1234, 16'h0, 16'h0040, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      n_cmp++; if ({o_jump, o_jump_addr} !== {1'b1, 16'h0040}) begin n_err++;
         $display("FAIL jump_z: got o_jump %b addr %h want 1 0040", o_jump, o_jump_addr); end
      @(posedge i_clk); #1;
      n_cmp++; if (o_jump !== 1'b0) begin n_err++;
         $display("FAIL jump_pulse: got o_jump %b want 0", o_jump); end
   endtask

   task automatic test_back_to_back_random;
      int c0, op, k;
      logic [15:0] a, b, imm, opb;
      logic use_imm, fwe, jmp, taken;
      logic [2:0] cond;
      logic [7:0] ie;
      logic [19:0] r;
      k = 80;
      c0 = submit_cnt;
      i_submit = 1'b1;
      for (int i = 0; i < k; i++) begin
         op = $urandom_range(0, 15);
         a = 16'($urandom); b = 16'($urandom); imm = 16'($urandom);
         if ($urandom_range(0, 3) == 0) a = 16'h8000;
         use_imm = 1'($urandom); fwe = ($urandom_range(0, 3) != 0);
         jmp = ($urandom_range(0, 2) == 0); cond = 3'($urandom); ie = 8'($urandom);
         load_instr(4'(op), a, b, imm, use_imm, ie, 1'b0, 1'b0, fwe, jmp, cond);
         opb = use_imm ? imm : b;
         r = ref_alu(op, a, opb, model_flags[1]);
         taken = jmp && ref_cond(int'(cond), model_flags);
         if (fwe) model_flags = r[19:16];
         n_cmp++; if (o_ready !== 1'b1) begin n_err++;
            $display("FAIL rnd_ready%0d: got %b want 1", i, o_ready); end
         @(posedge i_clk); #1;
         n_cmp++; if ({o_submit, o_data, o_flags, o_reg_ie} !== {1'b1, r[15:0], model_flags, ie}) begin n_err++;
            $display("FAIL rnd_result%0d op%0d a=%h b=%h: got submit %b data %h flags %b ie %h want 1 %h %b %h",
                     i, op, a, opb, o_submit, o_data, o_flags, o_reg_ie, r[15:0], model_flags, ie); end
         n_cmp++; if (o_jump !== taken || (taken && o_jump_addr !== (use_imm ? imm : a))) begin n_err++;
            $display("FAIL rnd_jump%0d cond%0d: got jump %b addr %h want %b %h", i, cond, o_jump, o_jump_addr, taken, use_imm ? imm : a); end
      end
      i_submit = 1'b0;
      @(posedge i_clk); #1;
      n_cmp++; if (submit_cnt - c0 != k || o_submit !== 1'b0) begin n_err++;
         $display("FAIL rnd_submits: got %0d submits want %0d", submit_cnt - c0, k); end
   endtask

   task automatic test_reset_busy;
      load_instr(4'd0, 16'h3000, 16'h0, 16'h0001, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      @(posedge i_clk); #1;
      n_cmp++; if ({o_ready, o_submit} !== 2'b00) begin n_err++;
         $display("FAIL rst_pre_busy: got ready %b submit %b want 0 0", o_ready, o_submit); end
      #2 i_rst = 1'b1;
      #1;
      n_cmp++; if ({o_submit, o_ready, o_flags} !== {2'b01, 4'h0}) begin n_err++;
         $display("FAIL rst_async: got submit %b ready %b flags %b want 0 1 0000", o_submit, o_ready, o_flags); end
      model_flags = 4'h0;
      @(negedge i_clk) i_rst = 1'b0;
      @(posedge i_clk); #1;
      i_mem_ack = 1'b1;
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      n_cmp++; if ({o_ready, o_submit} !== 2'b10) begin n_err++;
         $display("FAIL rst_stray_ack: got ready %b submit %b want 1 0", o_ready, o_submit); end
      i_submit = 1'b1;
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      n_cmp++; if ({o_submit, o_addr} !== {1'b1, 16'h3001}) begin n_err++;
         $display("FAIL rst_reissue: got submit %b addr %h want 1 3001", o_submit, o_addr); end
      @(posedge i_clk); #1;
      i_mem_ack = 1'b1;
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
   endtask

   initial begin
      test_reset;
      test_add_adc;
      test_sub;
      test_load;
      test_store;
      test_jump;
      test_back_to_back_random;
      test_reset_busy;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
